// File: rtl/taillight_decoder.sv
// Tail-light LED observer: tracks each side's 4-step sequence, counts completions, flags violations.
// Define TAILLIGHT_DECODER_SYNC_EN to pass led/sample_en through a two-flop synchronizer first.
module taillight_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [5:0]       led,
    input  logic             clr,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic             err,
    output logic [1:0]       err_side
);

    typedef enum logic [1:0] {S0, S1, S2, S3} step_e;

    logic       en_s;
    logic [5:0] led_s;

`ifdef TAILLIGHT_DECODER_SYNC_EN
    logic [6:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {sample_en, led};
            sync2_q <= sync1_q;
        end
    end

    assign en_s  = sync2_q[6];
    assign led_s = sync2_q[5:0];
`else
    assign en_s  = sample_en;
    assign led_s = led;
`endif

    // Returns {legal, step}.
    function automatic logic [2:0] decode_left(input logic [2:0] p);
        unique case (p)
            3'b000:  decode_left = 3'b100;
            3'b001:  decode_left = 3'b101;
            3'b011:  decode_left = 3'b110;
            3'b111:  decode_left = 3'b111;
            default: decode_left = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] decode_right(input logic [2:0] p);
        unique case (p)
            3'b000:  decode_right = 3'b100;
            3'b100:  decode_right = 3'b101;
            3'b110:  decode_right = 3'b110;
            3'b111:  decode_right = 3'b111;
            default: decode_right = 3'b000;
        endcase
    endfunction

    // Returns {violation, completed, next_state}.
    function automatic logic [3:0] track(input logic [1:0] cur, input logic [2:0] dec);
        logic [1:0] step;
        step = dec[1:0];
        if (!dec[2]) begin
            track = {2'b10, 2'b00};
        end else if (step == 2'd0) begin
            track = {1'b0, cur == 2'd3, 2'b00};
        end else if (step == cur + 2'd1) begin
            track = {2'b00, step};
        end else begin
            track = {2'b10, 2'b00};
        end
    endfunction

    // Illegal patterns light at least one LED, so they count as activity.
    function automatic logic [2:0] next_hold(input logic [2:0] hold, input logic [2:0] grp);
        if (grp != 3'b000)      next_hold = 3'd4;
        else if (hold != 3'd0)  next_hold = hold - 3'd1;
        else                    next_hold = 3'd0;
    endfunction

    step_e      left_st, right_st;
    logic [2:0] left_hold, right_hold;

    logic [3:0] left_trk, right_trk;
    logic [2:0] left_hold_nxt, right_hold_nxt;
    logic [1:0] viol;
    logic       left_done, right_done;

    always_comb begin
        left_trk       = track(left_st, decode_left(led_s[5:3]));
        right_trk      = track(right_st, decode_right(led_s[2:0]));
        left_hold_nxt  = next_hold(left_hold, led_s[5:3]);
        right_hold_nxt = next_hold(right_hold, led_s[2:0]);
        viol           = en_s ? {left_trk[3], right_trk[3]} : 2'b00;
        left_done      = en_s & left_trk[2];
        right_done     = en_s & right_trk[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_st    <= S0;
            right_st   <= S0;
            left_hold  <= 3'd0;
            right_hold <= 3'd0;
            mode       <= 2'b00;
            left_cnt   <= '0;
            right_cnt  <= '0;
            err        <= 1'b0;
            err_side   <= 2'b00;
        end else begin
            if (en_s) begin
                left_st    <= step_e'(left_trk[1:0]);
                right_st   <= step_e'(right_trk[1:0]);
                left_hold  <= left_hold_nxt;
                right_hold <= right_hold_nxt;
                mode       <= {left_hold_nxt != 3'd0, right_hold_nxt != 3'd0};
            end
            // A violation in the clearing cycle still lands; counters always clear.
            if (clr) begin
                left_cnt  <= '0;
                right_cnt <= '0;
                err_side  <= viol;
                err       <= |viol;
            end else begin
                if (left_done && left_cnt != '1)   left_cnt  <= left_cnt + CNT_W'(1);
                if (right_done && right_cnt != '1) right_cnt <= right_cnt + CNT_W'(1);
                err_side <= err_side | viol;
                err      <= err | (|viol);
            end
        end
    end

endmodule

// File: tb/tb_taillight_decoder.sv
// Randomized and directed bench for taillight_decoder against a rule-level reference model.
module tb_taillight_decoder;

`ifdef TAILLIGHT_DECODER_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int MAXC = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic [5:0] led = 6'd0;
    logic       clr = 1'b0;
    logic [1:0] mode;
    logic [7:0] left_cnt, right_cnt;
    logic       err;
    logic [1:0] err_side;

    int vectors = 0;
    int miscompares = 0;

    taillight_decoder #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .led       (led),
        .clr       (clr),
        .mode      (mode),
        .left_cnt  (left_cnt),
        .right_cnt (right_cnt),
        .err       (err),
        .err_side  (err_side)
    );

    always #5 clk = ~clk;

    // Reference model; index 1 = left, 0 = right.
    int       m_st[2];
    int       m_cnt[2];
    int       m_hold[2];
    bit [1:0] m_side;

    bit [2:0] lpat[4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    bit [2:0] rpat[4] = '{3'b000, 3'b100, 3'b110, 3'b111};

    function automatic int dec(input int side, input bit [2:0] p);
        for (int k = 0; k < 4; k++) begin
            if (side == 1 && lpat[k] == p) return k;
            if (side == 0 && rpat[k] == p) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_st[s] = 0; m_cnt[s] = 0; m_hold[s] = 0;
        end
        m_side = 2'b00;
    endtask

    task automatic model_step(input bit [5:0] l, input bit c);
        bit [1:0] vb;
        bit [2:0] p;
        int       n;
        vb = 2'b00;
        for (int s = 0; s < 2; s++) begin
            p = (s == 1) ? l[5:3] : l[2:0];
            n = dec(s, p);
            if (n < 0) vb[s] = 1'b1;
            else if (n == 0) begin
                if (m_st[s] == 3 && m_cnt[s] < MAXC) m_cnt[s]++;
                m_st[s] = 0;
            end else if (n == m_st[s] + 1) m_st[s] = n;
            else vb[s] = 1'b1;
            if (vb[s]) m_st[s] = 0;
            m_hold[s] = (p != 3'b000) ? 4 : ((m_hold[s] > 0) ? m_hold[s] - 1 : 0);
        end
        if (c) begin
            m_cnt[0] = 0; m_cnt[1] = 0; m_side = vb;
        end else begin
            m_side = m_side | vb;
        end
    endtask

    // One strobe; clr (if requested) lands in the cycle the decoder acts on this sample.
    task automatic strobe(input bit [5:0] l, input bit c);
        @(negedge clk);
        led = l;
        sample_en = 1'b1;
        if (EXTRA == 0) clr = c;
        @(negedge clk);
        sample_en = 1'b0;
        clr = 1'b0;
        led = 6'($urandom);
        for (int i = 0; i < EXTRA; i++) begin
            if (i == EXTRA - 1) clr = c;
            @(negedge clk);
            clr = 1'b0;
        end
        model_step(l, c);
    endtask

    task automatic clear_only();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_side = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sample_en = 1'b0; clr = 1'b0; led = 6'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 5;
        if (mode !== 2'b00)      begin miscompares++; $display("FAIL reset mode: got %b want 00", mode); end
        if (left_cnt !== 8'd0)   begin miscompares++; $display("FAIL reset left_cnt: got %0d want 0", left_cnt); end
        if (right_cnt !== 8'd0)  begin miscompares++; $display("FAIL reset right_cnt: got %0d want 0", right_cnt); end
        if (err !== 1'b0)        begin miscompares++; $display("FAIL reset err: got %b want 0", err); end
        if (err_side !== 2'b00)  begin miscompares++; $display("FAIL reset err_side: got %b want 00", err_side); end
    endtask

    task automatic test_left_seq();
        bit [1:0] want[5] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            strobe({lpat[k % 4], 3'b000}, 1'b0);
            vectors++;
            if (mode !== want[k]) begin
                miscompares++; $display("FAIL left_seq mode strobe %0d: got %b want %b", k, mode, want[k]);
            end
        end
        vectors += 2;
        if (left_cnt !== 8'd1) begin miscompares++; $display("FAIL left_seq left_cnt: got %0d want 1", left_cnt); end
        if (err !== 1'b0)      begin miscompares++; $display("FAIL left_seq err: got %b want 0", err); end
    endtask

    task automatic test_right_seq();
        bit [1:0] want;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++) strobe({3'b000, rpat[k]}, 1'b0);
        for (int z = 1; z <= 5; z++) begin
            strobe(6'b000000, 1'b0);
            want = (z < 4) ? 2'b01 : 2'b00;
            vectors++;
            if (mode !== want) begin
                miscompares++; $display("FAIL right_seq mode zero %0d: got %b want %b", z, mode, want);
            end
        end
        vectors++;
        if (right_cnt !== 8'd3) begin miscompares++; $display("FAIL right_seq right_cnt: got %0d want 3", right_cnt); end
    endtask

    task automatic test_both();
        do_reset();
        for (int j = 0; j < 13; j++) begin
            strobe({lpat[j % 4], rpat[j % 4]}, 1'b0);
            if (j > 0) begin
                vectors++;
                if (mode !== 2'b11) begin
                    miscompares++; $display("FAIL both mode strobe %0d: got %b want 11", j, mode);
                end
            end
            if (j % 4 == 0) begin
                vectors++;
                if (left_cnt !== 8'(j / 4) || right_cnt !== 8'(j / 4)) begin
                    miscompares++;
                    $display("FAIL both counts strobe %0d: got %0d/%0d want %0d", j, left_cnt, right_cnt, j / 4);
                end
            end
        end
    endtask

    task automatic test_skip();
        do_reset();
        strobe(6'b001000, 1'b0);
        strobe(6'b111000, 1'b0);
        vectors += 2;
        if (err !== 1'b1)       begin miscompares++; $display("FAIL skip err: got %b want 1", err); end
        if (err_side !== 2'b10) begin miscompares++; $display("FAIL skip err_side: got %b want 10", err_side); end
        strobe(6'b001000, 1'b0);
        clear_only();
        vectors += 2;
        if (err !== 1'b0)       begin miscompares++; $display("FAIL skip clr err: got %b want 0", err); end
        if (err_side !== 2'b00) begin miscompares++; $display("FAIL skip clr err_side: got %b want 00", err_side); end
        // Tracker restarted from S0 after the skip, so 001 then 011 is legal.
        strobe(6'b011000, 1'b0);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL skip restart err: got %b want 0", err); end
    endtask

    task automatic test_illegal_reset();
        do_reset();
        for (int k = 0; k < 5; k++) strobe({3'b000, rpat[k % 4]}, 1'b0);
        strobe(6'b000010, 1'b0);
        vectors += 3;
        if (err !== 1'b1)       begin miscompares++; $display("FAIL illegal err: got %b want 1", err); end
        if (err_side !== 2'b01) begin miscompares++; $display("FAIL illegal err_side: got %b want 01", err_side); end
        if (right_cnt !== 8'd1) begin miscompares++; $display("FAIL illegal right_cnt: got %0d want 1", right_cnt); end
        strobe(6'b001100, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({mode, left_cnt, right_cnt, err, err_side} !== 21'd0) begin
            miscompares++;
            $display("FAIL async reset: got mode %b cnt %0d/%0d err %b side %b want all 0",
                     mode, left_cnt, right_cnt, err, err_side);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        strobe(6'b000110, 1'b0);
        vectors++;
        if (err_side !== 2'b01) begin
            miscompares++; $display("FAIL post-reset from S0: got err_side %b want 01", err_side);
        end
    endtask

    task automatic test_clr_collision();
        do_reset();
        for (int k = 0; k < 5; k++) strobe({3'b000, rpat[k % 4]}, 1'b0);
        strobe(6'b000110, 1'b0);
        for (int k = 1; k < 4; k++) strobe({3'b000, rpat[k]}, 1'b0);
        strobe(6'b011000, 1'b1);
        vectors += 3;
        if (err !== 1'b1)       begin miscompares++; $display("FAIL collide err: got %b want 1", err); end
        if (err_side !== 2'b10) begin miscompares++; $display("FAIL collide err_side: got %b want 10", err_side); end
        if (right_cnt !== 8'd0) begin miscompares++; $display("FAIL collide right_cnt: got %0d want 0", right_cnt); end
    endtask

    task automatic test_ignore();
        do_reset();
        @(negedge clk);
        led = 6'b111111;
        repeat (4) @(negedge clk);
        led = 6'b010010;
        repeat (4) @(negedge clk);
        vectors += 2;
        if (mode !== 2'b00) begin miscompares++; $display("FAIL ignore mode: got %b want 00", mode); end
        if (err !== 1'b0)   begin miscompares++; $display("FAIL ignore err: got %b want 0", err); end
    endtask

    task automatic test_latency();
        int cyc;
        do_reset();
        @(negedge clk);
        led = 6'b001000;
        sample_en = 1'b1;
        cyc = 0;
        while (cyc < 10 && mode !== 2'b10) begin
            @(posedge clk);
            cyc++;
            #1;
            sample_en = 1'b0;
        end
        vectors++;
        if (cyc != 1 + EXTRA) begin
            miscompares++; $display("FAIL latency: got %0d cycles want %0d", cyc, 1 + EXTRA);
        end
        led = 6'd0;
    endtask

    task automatic test_random();
        bit [5:0] l;
        bit [2:0] p;
        bit       c;
        int       r, nx;
        do_reset();
        for (int t = 0; t < 300; t++) begin
            for (int s = 0; s < 2; s++) begin
                r = $urandom_range(0, 9);
                nx = (m_st[s] + 1) % 4;
                if (r < 6)      p = (s == 1) ? lpat[nx] : rpat[nx];
                else if (r < 8) p = 3'b000;
                else            p = 3'($urandom);
                if (s == 1) l[5:3] = p; else l[2:0] = p;
            end
            c = ($urandom_range(0, 19) == 0);
            strobe(l, c);
            vectors += 5;
            if (mode !== {m_hold[1] != 0, m_hold[0] != 0}) begin
                miscompares++; $display("FAIL random mode t=%0d: got %b want %b", t, mode,
                                        {m_hold[1] != 0, m_hold[0] != 0});
            end
            if (left_cnt !== 8'(m_cnt[1])) begin
                miscompares++; $display("FAIL random left_cnt t=%0d: got %0d want %0d", t, left_cnt, m_cnt[1]);
            end
            if (right_cnt !== 8'(m_cnt[0])) begin
                miscompares++; $display("FAIL random right_cnt t=%0d: got %0d want %0d", t, right_cnt, m_cnt[0]);
            end
            if (err !== (m_side != 2'b00)) begin
                miscompares++; $display("FAIL random err t=%0d: got %b want %b", t, err, m_side != 2'b00);
            end
            if (err_side !== m_side) begin
                miscompares++; $display("FAIL random err_side t=%0d: got %b want %b", t, err_side, m_side);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int n = 0; n < 255; n++)
            for (int k = 1; k <= 4; k++) strobe({lpat[k % 4], 3'b000}, 1'b0);
        vectors++;
        if (left_cnt !== 8'd255) begin miscompares++; $display("FAIL sat reach: got %0d want 255", left_cnt); end
        for (int k = 1; k <= 4; k++) strobe({lpat[k % 4], 3'b000}, 1'b0);
        vectors += 2;
        if (left_cnt !== 8'd255) begin miscompares++; $display("FAIL sat hold: got %0d want 255", left_cnt); end
        if (err !== 1'b0)        begin miscompares++; $display("FAIL sat err: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_left_seq();
        test_right_seq();
        test_both();
        test_skip();
        test_illegal_reset();
        test_clr_collision();
        test_ignore();
        test_latency();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
